// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared definitions for the instruction-fetch front end.
// Holds the bus widths, the opcodes the next-PC predictor decodes, the fetch FSM
// state encoding and a helper that extracts the JAL/branch PC-relative offset.
package inst_fetch_pkg;

  localparam int unsigned ADDR_WID = 32;
  localparam int unsigned INST_WID = 32;
  localparam int unsigned DATA_WID = 32;

  localparam logic [6:0] OPCODE_B   = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL = 7'b1101111;

  typedef enum logic {
    StIdle    = 1'b0,
    StWaitMem = 1'b1
  } fetch_state_e;

  // Sign-extended PC-relative offset of a JAL (J-type) or conditional branch (B-type).
  function automatic logic [ADDR_WID-1:0] target_imm(input logic [INST_WID-1:0] i);
    logic [ADDR_WID-1:0] imm;
    if (i[6:0] == OPCODE_JAL) begin
      imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    end else begin
      imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    end
    return imm;
  endfunction

endpackage

// File: rtl/inst_fetch_bht.sv
// inst_fetch_bht: branch history table of 2-bit saturating counters.
// Ports:
//   clk, rst, rdy    clock, synchronous active-high reset, global ready (holds state when low)
//   i_rd_idx         lookup index (combinational read)
//   o_taken          predicted taken = counter MSB at i_rd_idx
//   i_upd            commit of a conditional branch
//   i_upd_idx        index of the committed branch
//   i_upd_taken      actual outcome; counter counts up when taken, down otherwise
// An update and a lookup of the same entry in one cycle: the lookup sees the old counter.
module inst_fetch_bht #(
  parameter int unsigned BHT_IDX_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [BHT_IDX_W-1:0] i_rd_idx,
  output logic                 o_taken,
  input  logic                 i_upd,
  input  logic [BHT_IDX_W-1:0] i_upd_idx,
  input  logic                 i_upd_taken
);

  localparam int unsigned Entries = 2 ** BHT_IDX_W;

  logic [1:0] r_cnt [Entries];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        r_cnt[i] <= 2'b01;
      end
    end else if (rdy && i_upd) begin
      if (i_upd_taken) begin
        if (r_cnt[i_upd_idx] != 2'b11) r_cnt[i_upd_idx] <= r_cnt[i_upd_idx] + 2'd1;
      end else begin
        if (r_cnt[i_upd_idx] != 2'b00) r_cnt[i_upd_idx] <= r_cnt[i_upd_idx] - 2'd1;
      end
    end
  end

  assign o_taken = r_cnt[i_rd_idx][1];

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch front end (producer side of fetch -> decode).
// Holds the fetch PC and a direct-mapped, one-word-per-entry instruction cache,
// requests misses from the memory controller and predicts the next PC.
// Optional feature: define BHT_EN to predict conditional branches with a 2-bit
// counter BHT; without it branches are always predicted not-taken and the br_*
// inputs are ignored.
// Ports:
//   clk, rst, rdy            clock, synchronous active-high reset, global ready
//   stall                    downstream full: deliver nothing this cycle
//   rollback, rollback_pc    flush from ROB and corrected fetch PC
//   mc_en, mc_pc             miss request (held until mc_done), word-aligned address
//   mc_done, mc_data         returned instruction word
//   br_upd, br_pc, br_taken  committed conditional branch outcome (BHT_EN only)
//   inst_done                one-cycle valid to decoder with inst, inst_pc, inst_pre_j
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned ICACHE_IDX_W = 8,
  parameter int unsigned BHT_IDX_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                stall,
  input  logic                rollback,
  input  logic [ADDR_WID-1:0] rollback_pc,
  input  logic                mc_done,
  input  logic [DATA_WID-1:0] mc_data,
  output logic                mc_en,
  output logic [ADDR_WID-1:0] mc_pc,
  input  logic                br_upd,
  input  logic [ADDR_WID-1:0] br_pc,
  input  logic                br_taken,
  output logic                inst_done,
  output logic [INST_WID-1:0] inst,
  output logic [ADDR_WID-1:0] inst_pc,
  output logic                inst_pre_j
);

  localparam int unsigned IcEntries = 2 ** ICACHE_IDX_W;
  localparam int unsigned TagW      = ADDR_WID - ICACHE_IDX_W - 2;

  fetch_state_e        r_state, w_state_next;
  logic [ADDR_WID-1:0] r_pc, w_pc_next;
  logic                r_inst_done, w_inst_done_next;
  logic [INST_WID-1:0] r_inst, w_inst_next;
  logic [ADDR_WID-1:0] r_inst_pc, w_inst_pc_next;
  logic                r_inst_pre_j, w_inst_pre_j_next;
  logic                r_mc_en, w_mc_en_next;
  logic [ADDR_WID-1:0] r_mc_pc, w_mc_pc_next;
  logic                w_fill;

  logic [IcEntries-1:0] r_valid;
  logic [TagW-1:0]      r_tag  [IcEntries];
  logic [INST_WID-1:0]  r_data [IcEntries];

  logic [ICACHE_IDX_W-1:0] w_idx, w_fill_idx;
  logic [TagW-1:0]         w_tag, w_fill_tag;
  logic                    w_hit;
  logic [INST_WID-1:0]     w_word;
  logic                    w_bht_taken;
  logic                    w_pred;
  logic [ADDR_WID-1:0]     w_next_pc;

  assign w_idx      = r_pc[ICACHE_IDX_W+1:2];
  assign w_tag      = r_pc[ADDR_WID-1:ICACHE_IDX_W+2];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_word     = r_data[w_idx];
  // A fill always targets the outstanding request, even if the PC was redirected meanwhile.
  assign w_fill_idx = r_mc_pc[ICACHE_IDX_W+1:2];
  assign w_fill_tag = r_mc_pc[ADDR_WID-1:ICACHE_IDX_W+2];

`ifdef BHT_EN
  logic w_unused_br_pc;
  assign w_unused_br_pc = ^{br_pc[ADDR_WID-1:BHT_IDX_W+2], br_pc[1:0]};

  inst_fetch_bht #(
    .BHT_IDX_W(BHT_IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .i_rd_idx   (r_pc[BHT_IDX_W+1:2]),
    .o_taken    (w_bht_taken),
    .i_upd      (br_upd),
    .i_upd_idx  (br_pc[BHT_IDX_W+1:2]),
    .i_upd_taken(br_taken)
  );
`else
  localparam int unsigned unused_bht_idx_w = BHT_IDX_W;
  logic w_unused_br;
  assign w_unused_br = ^{br_upd, br_pc, br_taken};
  assign w_bht_taken = 1'b0;
`endif

  // Next-PC prediction from the cached word at the current PC.
  always_comb begin
    w_pred    = 1'b0;
    w_next_pc = r_pc + 32'd4;
    if (w_word[6:0] == OPCODE_JAL) begin
      w_pred    = 1'b1;
      w_next_pc = r_pc + target_imm(w_word);
    end else if ((w_word[6:0] == OPCODE_B) && w_bht_taken) begin
      w_pred    = 1'b1;
      w_next_pc = r_pc + target_imm(w_word);
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_inst_done_next  = 1'b0;
    w_inst_next       = r_inst;
    w_inst_pc_next    = r_inst_pc;
    w_inst_pre_j_next = r_inst_pre_j;
    w_mc_en_next      = r_mc_en;
    w_mc_pc_next      = r_mc_pc;
    w_fill            = 1'b0;
    case (r_state)
      StIdle: begin
        if (rollback) begin
          w_pc_next = rollback_pc;
        end else if (!stall) begin
          if (w_hit) begin
            w_inst_done_next  = 1'b1;
            w_inst_next       = w_word;
            w_inst_pc_next    = r_pc;
            w_inst_pre_j_next = w_pred;
            w_pc_next         = w_next_pc;
          end else begin
            w_mc_en_next = 1'b1;
            w_mc_pc_next = {r_pc[ADDR_WID-1:2], 2'b00};
            w_state_next = StWaitMem;
          end
        end
      end
      StWaitMem: begin
        if (rollback) w_pc_next = rollback_pc;
        if (mc_done) begin
          w_fill       = 1'b1;
          w_mc_en_next = 1'b0;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_pc         <= '0;
      r_inst_done  <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_pre_j <= 1'b0;
      r_mc_en      <= 1'b0;
      r_mc_pc      <= '0;
      r_valid      <= '0;
    end else if (rdy) begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_inst_done  <= w_inst_done_next;
      r_inst       <= w_inst_next;
      r_inst_pc    <= w_inst_pc_next;
      r_inst_pre_j <= w_inst_pre_j_next;
      r_mc_en      <= w_mc_en_next;
      r_mc_pc      <= w_mc_pc_next;
      if (w_fill) r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag/data arrays need no reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (!rst && rdy && w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mc_data;
    end
  end

  assign mc_en      = r_mc_en;
  assign mc_pc      = r_mc_pc;
  assign inst_done  = r_inst_done;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_pre_j = r_inst_pre_j;

endmodule
